// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port. A requester can lock
// the grant for multi-beat writebacks. The winning beat is registered onto the write port.
module wb_port_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int DISCARD_R0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req_valid,
    input  logic [2:0]    req_lock,
    input  logic [AW-1:0] req_waddr0,
    input  logic [AW-1:0] req_waddr1,
    input  logic [AW-1:0] req_waddr2,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    input  logic [DW-1:0] req_wdata2,
    input  logic          rf_stall,
    output logic [2:0]    req_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [1:0]    rf_sel,
    output logic          lock_active
);

    logic [1:0]    ptr;
    logic [1:0]    lock_owner;
    logic [2:0]    rr_grant;
    logic          accept;
    logic [1:0]    win;
    logic [AW-1:0] win_waddr;
    logic [DW-1:0] win_wdata;
    logic          discard;

    // Round-robin search starting at ptr
    always_comb begin
        rr_grant = 3'b000;
        case (ptr)
            2'd1: begin
                if (req_valid[1])      rr_grant = 3'b010;
                else if (req_valid[2]) rr_grant = 3'b100;
                else if (req_valid[0]) rr_grant = 3'b001;
            end
            2'd2: begin
                if (req_valid[2])      rr_grant = 3'b100;
                else if (req_valid[0]) rr_grant = 3'b001;
                else if (req_valid[1]) rr_grant = 3'b010;
            end
            default: begin
                if (req_valid[0])      rr_grant = 3'b001;
                else if (req_valid[1]) rr_grant = 3'b010;
                else if (req_valid[2]) rr_grant = 3'b100;
            end
        endcase
    end

    // A held lock shuts out everyone but the owner, even while the owner is idle
    always_comb begin
        req_ready = 3'b000;
        if (!rst && !rf_stall) begin
            if (lock_active) begin
                case (lock_owner)
                    2'd1:    req_ready[1] = req_valid[1];
                    2'd2:    req_ready[2] = req_valid[2];
                    default: req_ready[0] = req_valid[0];
                endcase
            end else begin
                req_ready = rr_grant;
            end
        end
    end

    always_comb begin
        accept    = |(req_ready & req_valid);
        win       = 2'd0;
        win_waddr = req_waddr0;
        win_wdata = req_wdata0;
        if (req_ready[1]) begin
            win       = 2'd1;
            win_waddr = req_waddr1;
            win_wdata = req_wdata1;
        end else if (req_ready[2]) begin
            win       = 2'd2;
            win_waddr = req_waddr2;
            win_wdata = req_wdata2;
        end
    end

    assign discard = (DISCARD_R0 != 0) && (win_waddr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= 2'd0;
            lock_active <= 1'b0;
            lock_owner  <= 2'd0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            rf_sel      <= 2'b11;
        end else if (accept) begin
            rf_waddr <= win_waddr;
            rf_wdata <= win_wdata;
            rf_we    <= !discard;
            rf_sel   <= discard ? 2'b11 : win;
            if (req_lock[win]) begin
                lock_active <= 1'b1;
                lock_owner  <= win;
            end else begin
                lock_active <= 1'b0;
                ptr         <= (win == 2'd2) ? 2'd0 : win + 2'd1;
            end
        end else begin
            rf_we  <= 1'b0;
            rf_sel <= 2'b11;
        end
    end

endmodule
